// File: rtl/bsg_circular_ptr_pkg.sv
// Shared constants and occupancy-state type for the 64-slot circular pointer consumer.
package bsg_circular_ptr_pkg;

    localparam int unsigned Slots    = 64;
    localparam int unsigned PtrWidth = 6;
    localparam int unsigned CntWidth = 7;

    typedef enum logic [1:0] {
        OccEmpty   = 2'd0,
        OccPartial = 2'd1,
        OccFull    = 2'd2
    } occ_state_e;

    function automatic occ_state_e occ_state(input logic [CntWidth-1:0] count);
        if (count == '0) begin
            return OccEmpty;
        end else if (count == CntWidth'(Slots)) begin
            return OccFull;
        end else begin
            return OccPartial;
        end
    endfunction

endpackage

// File: rtl/bsg_circular_ptr_rd_p64.sv
// 6-bit wrap-around read pointer; n_ptr_o is the value the pointer takes at the next edge.
module bsg_circular_ptr_rd_p64
    import bsg_circular_ptr_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                add_i,
    output logic [PtrWidth-1:0] ptr_o,
    output logic [PtrWidth-1:0] n_ptr_o
);

    logic [PtrWidth-1:0] ptr_q;
    logic [PtrWidth-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (add_i) begin
            ptr_d = ptr_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o   = ptr_q;
    assign n_ptr_o = ptr_d;

endmodule

// File: rtl/bsg_circular_ptr_consumer_p64.sv
// Consumer side of a 64-slot circular buffer: read pointer, occupancy count and sticky
// overflow/underflow flags; the producer pointer is reconstructed from rptr + count.
module bsg_circular_ptr_consumer_p64
    import bsg_circular_ptr_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                enq_i,
    input  logic                yumi_i,
    output logic                v_o,
    output logic                full_o,
    output logic [PtrWidth-1:0] rptr_o,
    output logic [PtrWidth-1:0] n_rptr_o,
    output logic [PtrWidth-1:0] wptr_o,
    output logic [CntWidth-1:0] count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    logic [CntWidth-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    occ_state_e          occ;
    logic                enq_eff;
    logic                yumi_eff;

    // Status comes only from registered count, so v_o/full_o never depend on enq_i/yumi_i.
    assign occ      = occ_state(count_q);
    assign v_o      = (occ != OccEmpty);
    assign full_o   = (occ == OccFull);
    assign enq_eff  = enq_i & ~full_o;
    assign yumi_eff = yumi_i & v_o;

    bsg_circular_ptr_rd_p64 u_rptr (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .add_i     (yumi_eff),
        .ptr_o     (rptr_o),
        .n_ptr_o   (n_rptr_o)
    );

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q | (enq_i & full_o);
        underflow_d = underflow_q | (yumi_i & ~v_o);
        if (enq_eff && !yumi_eff) begin
            count_d = count_q + CntWidth'(1);
        end else if (!enq_eff && yumi_eff) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    // At count 64 the low six bits of the count are zero, so wptr lands on rptr.
    assign wptr_o      = rptr_o + count_q[PtrWidth-1:0];

endmodule

// File: tb/tb_bsg_circular_ptr_consumer_p64.sv
// Directed self-checking bench for bsg_circular_ptr_consumer_p64.
module tb_bsg_circular_ptr_consumer_p64;

    logic       clk;
    logic       reset_n_i;
    logic       enq_i;
    logic       yumi_i;
    logic       v_o;
    logic       full_o;
    logic [5:0] rptr_o;
    logic [5:0] n_rptr_o;
    logic [5:0] wptr_o;
    logic [6:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    int checks = 0;
    int errors = 0;

    bsg_circular_ptr_consumer_p64 dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .enq_i       (enq_i),
        .yumi_i      (yumi_i),
        .v_o         (v_o),
        .full_o      (full_o),
        .rptr_o      (rptr_o),
        .n_rptr_o    (n_rptr_o),
        .wptr_o      (wptr_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; outputs are stable 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input int rp, input int wp);
        check({tag, ".count"}, 32'(count_o), 32'(cnt));
        check({tag, ".rptr"}, 32'(rptr_o), 32'(rp));
        check({tag, ".wptr"}, 32'(wptr_o), 32'(wp));
        check({tag, ".v"}, 32'(v_o), 32'(cnt != 0));
        check({tag, ".full"}, 32'(full_o), 32'(cnt == 64));
    endtask

    initial begin
        reset_n_i = 1'b0;
        enq_i     = 1'b0;
        yumi_i    = 1'b0;
        step(2);
        check_state("reset", 0, 0, 0);
        check("reset.n_rptr", 32'(n_rptr_o), 32'd0);
        check("reset.ovf", 32'(overflow_o), 32'd0);
        check("reset.unf", 32'(underflow_o), 32'd0);

        // Fill all 64 slots
        reset_n_i = 1'b1;
        enq_i     = 1'b1;
        step(64);
        enq_i = 1'b0;
        check_state("fill64", 64, 0, 0);
        check("fill64.ovf", 32'(overflow_o), 32'd0);

        // Enq while full: count held, overflow sticky
        enq_i = 1'b1;
        step(1);
        enq_i = 1'b0;
        check("ovf.count", 32'(count_o), 32'd64);
        check("ovf.set", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("ovf.hold", 32'(overflow_o), 32'd1);
        end

        // Drain 63 -> rptr 63, count 1; then enq 4 -> count 5
        yumi_i = 1'b1;
        step(63);
        yumi_i = 1'b0;
        check_state("drain63", 1, 63, 0);
        enq_i = 1'b1;
        step(4);
        enq_i = 1'b0;
        check_state("rp63c5", 5, 63, 4);
        yumi_i = 1'b1;
        #1;
        check("wrap.n_rptr", 32'(n_rptr_o), 32'd0);
        step(1);
        yumi_i = 1'b0;
        check_state("wrap", 4, 0, 4);
        check("wrap.unf", 32'(underflow_o), 32'd0);

        // Count 10, simultaneous enq+yumi for 20 cycles
        enq_i = 1'b1;
        step(6);
        check_state("c10", 10, 0, 10);
        yumi_i = 1'b1;
        step(20);
        enq_i  = 1'b0;
        yumi_i = 1'b0;
        check_state("simul20", 10, 20, 30);

        // Drain to empty, then enq+yumi while empty
        yumi_i = 1'b1;
        step(10);
        yumi_i = 1'b0;
        check_state("empty", 0, 30, 30);
        check("empty.unf", 32'(underflow_o), 32'd0);
        enq_i  = 1'b1;
        yumi_i = 1'b1;
        step(1);
        enq_i  = 1'b0;
        yumi_i = 1'b0;
        check_state("unf", 1, 30, 31);
        check("unf.set", 32'(underflow_o), 32'd1);

        // Fill, then enq+yumi while full: enq dropped, rptr advances
        enq_i = 1'b1;
        step(63);
        enq_i = 1'b0;
        check_state("refill", 64, 30, 30);
        enq_i  = 1'b1;
        yumi_i = 1'b1;
        step(1);
        enq_i  = 1'b0;
        yumi_i = 1'b0;
        check_state("fullsim", 63, 31, 30);

        // Down to 30, then reset with enq asserted
        yumi_i = 1'b1;
        step(33);
        yumi_i = 1'b0;
        check_state("c30", 30, 0, 30);
        reset_n_i = 1'b0;
        enq_i     = 1'b1;
        step(1);
        check_state("midrst", 0, 0, 0);
        check("midrst.ovf", 32'(overflow_o), 32'd0);
        check("midrst.unf", 32'(underflow_o), 32'd0);
        check("midrst.n_rptr", 32'(n_rptr_o), 32'd0);
        reset_n_i = 1'b1;
        enq_i     = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
